mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter DW, default 32, meaning operand/result width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_valid  input  1  operation request.
REQ-005 SHALL have port start_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 SHALL have port funct3  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port rs1_data  input  DW  operand A, from register file read port 1.
REQ-008 SHALL have port rs2_data  input  DW  operand B, from register file read port 2.
REQ-009 SHALL have port rd_addr_in  input  5  destination register tag.
REQ-010 SHALL have port flush  input  1  synchronous abort of any in-flight op.
REQ-011 SHALL have port wb_valid  output  1  result available for register-file writeback.
REQ-012 SHALL have port wb_ready  input  1  writeback consumer accepts result.
REQ-013 SHALL have port wb_rd_addr  output  5  captured rd_addr_in.
REQ-014 SHALL have port wb_data  output  DW  result.
REQ-015 SHALL have port busy  output  1  high in CALC or DONE.

Function
REQ-016 SHALL implement FSM IDLE, CALC, DONE; accept = start_valid && start_ready && !flush.
REQ-017 On accept, SHALL latch funct3, rs1_data, rs2_data, rd_addr_in; go to CALC with iteration counter 0.
REQ-018 CALC SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes; after DW steps go to DONE.
REQ-019 Accept on edge N SHALL give wb_valid high from edge N+DW; this is fixed latency for all non-special ops.
REQ-020 Signed ops SHALL take magnitudes; MULHSU treats rs1 signed, rs2 unsigned; final result negated when signs require.
REQ-021 MUL SHALL return low DW bits of the 2*DW product; MULH/MULHSU/MULHU SHALL return high DW bits.
REQ-022 DIV/DIVU SHALL truncate quotient toward zero; REM/REM sign SHALL follow dividend.
REQ-023 Divide by zero SHALL skip CALC: quotient all ones, remainder = rs1_data; wb_valid from edge N+1.
REQ-024 DIV/REM with rs1 = most-negative and rs2 = -1 SHALL skip CALC: quotient = rs1_data, remainder 0; wb_valid from edge N+1.
REQ-025 In DONE, wb_valid, wb_data, wb_rd_addr SHALL hold stable until wb_valid && wb_ready; then IDLE next edge.
REQ-026 No new request SHALL be accepted in the same cycle as a writeback handshake; start_ready rises the cycle after.
REQ-027 rd_addr_in = 0 SHALL still compute and complete handshake; x0 suppression is the register file's job.
REQ-028 flush SHALL return FSM to IDLE on the next edge from any state, deassert wb_valid, discard result; flush overrides start_valid.
REQ-029 Operand inputs SHALL be ignored outside the accept cycle.

Reset
REQ-030 rst SHALL force IDLE, counter 0, and all internal registers 0 immediately.
REQ-031 Under reset, outputs SHALL be start_ready 0, wb_valid 0, busy 0, wb_data 0, wb_rd_addr 0; start_ready rises the first cycle after rst deasserts.
REQ-032 Reset mid-CALC or mid-DONE SHALL drop the op without writeback.

Structure
REQ-033 Package mdu_pkg SHALL hold the op enum (funct3 encodings), the FSM state enum and DW default.
REQ-034 SHALL be a single module with no sub-modules; multiply and divide share one 2*DW accumulator and counter.

Verification
REQ-035 MUL 7 x 0xFFFFFFFD accepted at edge N -> wb_data 0xFFFFFFEB, wb_valid first high after edge N+32.
REQ-036 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-037 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-038 DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0; each wb_valid after edge N+1.
REQ-039 Hold wb_ready low 5 cycles in DONE -> wb_valid, wb_data, wb_rd_addr stable, start_ready 0; back-to-back second op accepted only after handshake.
REQ-040 flush at CALC iteration 10, then separately rst at iteration 20 -> IDLE, wb_valid never asserts, next op result correct.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - MDU_DW   : default operand/result width
//   - op_e     : funct3 encodings of the M-extension operations
//   - state_e  : control FSM states
//   - op_is_div: true for the four divide/remainder operations
package mdu_pkg;

   localparam int MDU_DW = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Divide-class ops all have funct3[2] set.
   function automatic logic op_is_div(input op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/mdu.sv
// Iterative radix-2 multiply/divide unit (RISC-V M-extension semantics).
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on
// operand magnitudes, sharing a single 2*DW accumulator and step counter.
// Divide-by-zero and signed overflow bypass the iteration loop.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_valid/ready   request handshake (ready only in IDLE)
//   funct3              operation select (see mdu_pkg::op_e)
//   rs1_data, rs2_data  operands A and B, sampled only on accept
//   rd_addr_in          destination tag, returned on wb_rd_addr
//   flush               synchronous abort of any in-flight op
//   wb_valid/ready      result handshake; outputs held until taken
//   wb_rd_addr, wb_data writeback tag and result
//   busy                high while an op is in CALC or DONE
module mdu
   import mdu_pkg::*;
#(
   parameter int DW = MDU_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_valid,
   output logic          start_ready,
   input  logic [2:0]    funct3,
   input  logic [DW-1:0] rs1_data,
   input  logic [DW-1:0] rs2_data,
   input  logic [4:0]    rd_addr_in,
   input  logic          flush,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [4:0]    wb_rd_addr,
   output logic [DW-1:0] wb_data,
   output logic          busy
);

   localparam int CW = $clog2(DW);

   state_e          state_reg, state_next;
   op_e             op_reg;
   logic [4:0]      rd_reg;
   logic [DW-1:0]   b_reg;
   logic [2*DW-1:0] acc_reg;
   logic [CW-1:0]   cnt_reg;
   logic            neg_reg;
   logic            special_reg;
   logic [DW-1:0]   result_reg;

   logic            accept;
   logic            calc_last;

   // ---------------- request decode (only meaningful on accept) -----------
   op_e             op_in;
   logic            a_sign, b_sign, neg_in;
   logic [DW-1:0]   a_mag, b_mag;
   logic            div_zero, div_ovf;
   logic [DW-1:0]   special_result;

   always_comb begin
      op_in  = op_e'(funct3);
      a_sign = rs1_data[DW-1] &&
               (op_in == OP_MUL || op_in == OP_MULH || op_in == OP_MULHSU ||
                op_in == OP_DIV || op_in == OP_REM);
      b_sign = rs2_data[DW-1] &&
               (op_in == OP_MUL || op_in == OP_MULH ||
                op_in == OP_DIV || op_in == OP_REM);
      a_mag  = a_sign ? -rs1_data : rs1_data;
      b_mag  = b_sign ? -rs2_data : rs2_data;

      // Remainder sign follows the dividend; everything else is sign XOR.
      if (op_in == OP_REM)
         neg_in = a_sign;
      else if (op_in == OP_DIVU || op_in == OP_REMU)
         neg_in = 1'b0;
      else
         neg_in = a_sign ^ b_sign;

      div_zero = op_is_div(op_in) && (rs2_data == '0);
      div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                 (rs1_data == {1'b1, {(DW-1){1'b0}}}) && (rs2_data == '1);

      special_result = '0;
      if (div_zero)
         special_result = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : rs1_data;
      else if (div_ovf)
         special_result = (op_in == OP_DIV) ? rs1_data : '0;
   end

   // ---------------- one iteration step ------------------------------------
   logic [DW:0]     mul_sum;
   logic [2*DW-1:0] mul_step;
   logic            div_fits;
   logic [DW-1:0]   div_sub;
   logic [2*DW-1:0] div_step;
   logic [2*DW-1:0] acc_step;
   logic [2*DW-1:0] prod_fix;
   logic [DW-1:0]   quo, rem;
   logic [DW-1:0]   result_calc;

   always_comb begin
      // Multiply: low half holds the remaining multiplier bits, high half
      // accumulates; the carry shifts into the top on the right shift.
      mul_sum  = {1'b0, acc_reg[2*DW-1:DW]} + {1'b0, b_reg};
      mul_step = acc_reg[0] ? {mul_sum, acc_reg[DW-1:1]}
                            : {1'b0, acc_reg[2*DW-1:1]};

      // Restoring divide: shift {rem,quo} left, trial-subtract the divisor.
      // The shifted remainder is DW+1 bits wide, hence the wider compare;
      // when it fits, the difference always fits back into DW bits.
      div_fits = {acc_reg[2*DW-1:DW-1]} >= {1'b0, b_reg};
      div_sub  = acc_reg[2*DW-2:DW-1] - b_reg;
      div_step = div_fits ? {div_sub, acc_reg[DW-2:0], 1'b1}
                          : {acc_reg[2*DW-2:0], 1'b0};

      acc_step = op_is_div(op_reg) ? div_step : mul_step;

      prod_fix = neg_reg ? -acc_step : acc_step;
      quo      = acc_step[DW-1:0];
      rem      = acc_step[2*DW-1:DW];

      result_calc = '0;
      case (op_reg)
         OP_MUL:                        result_calc = prod_fix[DW-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  result_calc = prod_fix[2*DW-1:DW];
         OP_DIV, OP_DIVU:               result_calc = neg_reg ? -quo : quo;
         OP_REM, OP_REMU:               result_calc = neg_reg ? -rem : rem;
         default:                       result_calc = '0;
      endcase
   end

   // ---------------- FSM ----------------------------------------------------
   assign accept    = start_valid && start_ready && !flush;
   assign calc_last = (state_reg == ST_CALC) &&
                      (special_reg || (cnt_reg == CW'(DW-1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept)    state_next = ST_CALC;
         ST_CALC: if (calc_last) state_next = ST_DONE;
         ST_DONE: if (wb_ready)  state_next = ST_IDLE;
         default:                state_next = ST_IDLE;
      endcase
      if (flush)
         state_next = ST_IDLE;
   end

   // start_ready is masked by rst so it stays low throughout reset.
   always_comb begin
      start_ready = (state_reg == ST_IDLE) && !rst;
      busy        = (state_reg == ST_CALC) || (state_reg == ST_DONE);
      wb_valid    = (state_reg == ST_DONE);
   end

   assign wb_data    = result_reg;
   assign wb_rd_addr = rd_reg;

   // ---------------- datapath registers ------------------------------------
   // Special cases spend exactly one cycle in CALC with the result already
   // loaded, giving their one-edge latency without an extra state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg      <= OP_MUL;
         rd_reg      <= '0;
         b_reg       <= '0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         neg_reg     <= 1'b0;
         special_reg <= 1'b0;
         result_reg  <= '0;
      end else if (accept) begin
         op_reg      <= op_in;
         rd_reg      <= rd_addr_in;
         b_reg       <= b_mag;
         acc_reg     <= {{DW{1'b0}}, a_mag};
         cnt_reg     <= '0;
         neg_reg     <= neg_in;
         special_reg <= div_zero || div_ovf;
         if (div_zero || div_ovf)
            result_reg <= special_result;
      end else if (state_reg == ST_CALC && !flush && !special_reg) begin
         acc_reg <= acc_step;
         cnt_reg <= cnt_reg + CW'(1);
         if (cnt_reg == CW'(DW-1))
            result_reg <= result_calc;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors, randomized ops against a
// plain-arithmetic reference model, handshake stalls, flush and reset aborts.
module tb_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_addr_in;
   logic        flush;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mdu #(.DW(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .funct3      (funct3),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .rd_addr_in  (rd_addr_in),
      .flush       (flush),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_rd_addr  (wb_rd_addr),
      .wb_data     (wb_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: straight 64-bit arithmetic with the RISC-V special cases.
   function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      r  = '0;
      case (f3)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else begin p = ua / ub; r = p[31:0]; end
         end
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: begin
            if (b == 0) r = a;
            else begin p = ua % ub; r = p[31:0]; end
         end
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 32;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Called at a negedge with the unit idle; returns at a negedge, idle.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int hold,
                         input bit pester);
      int lat;
      int exp_lat;
      exp_lat = ref_lat(f3, a, b);
      check("ready_before", 64'(start_ready), 64'(1));
      start_valid = 1'b1;
      funct3      = f3;
      rs1_data    = a;
      rs2_data    = b;
      rd_addr_in  = rd;
      @(negedge clk);
      // Accept edge passed; scramble operands to prove they are not re-sampled.
      start_valid = 1'b0;
      funct3      = 3'($urandom);
      rs1_data    = 32'($urandom);
      rs2_data    = 32'($urandom);
      rd_addr_in  = 5'($urandom);
      check("busy_after_accept", 64'(busy), 64'(1));
      lat = 0;
      while (!wb_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("wb_data", 64'(wb_data), 64'(exp));
      check("wb_rd_addr", 64'(wb_rd_addr), 64'(rd));
      for (int i = 0; i < hold; i++) begin
         if (pester) begin
            start_valid = 1'b1;
            funct3      = 3'($urandom);
            rs1_data    = 32'($urandom);
            rs2_data    = 32'($urandom);
         end
         @(negedge clk);
         check("hold_valid", 64'(wb_valid), 64'(1));
         check("hold_data", 64'(wb_data), 64'(exp));
         check("hold_rd", 64'(wb_rd_addr), 64'(rd));
         check("hold_ready", 64'(start_ready), 64'(0));
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready    = 1'b0;
      start_valid = 1'b0;
      check("post_valid", 64'(wb_valid), 64'(0));
      check("post_busy", 64'(busy), 64'(0));
      check("post_ready", 64'(start_ready), 64'(1));
      $display("op f3=%0d a=%08h b=%08h rd=%0d -> %08h lat=%0d exp=%08h", f3, a, b, rd,
               wb_data, lat, exp);
   endtask

   // Directed vectors with hand-derived results.
   localparam int NDIR = 12;
   logic [2:0]  dir_f3  [NDIR] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6,
                                   3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
   logic [31:0] dir_a   [NDIR] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                                   32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                   32'd5, 32'd5, 32'h80000000, 32'h80000000};
   logic [31:0] dir_b   [NDIR] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd2,
                                   32'd2, 32'd2, 32'd7, 32'd7,
                                   32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] dir_exp [NDIR] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF,
                                   32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                   32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

   initial begin
      int seen;
      logic [2:0]  f3;
      logic [31:0] a, b;

      rst         = 1'b1;
      start_valid = 1'b0;
      funct3      = '0;
      rs1_data    = '0;
      rs2_data    = '0;
      rd_addr_in  = '0;
      flush       = 1'b0;
      wb_ready    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(start_ready), 64'(0));
      check("rst_valid", 64'(wb_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_data", 64'(wb_data), 64'(0));
      check("rst_rd", 64'(wb_rd_addr), 64'(0));
      rst = 1'b0;
      #1;
      check("rst_release_ready", 64'(start_ready), 64'(1));
      @(negedge clk);

      for (int i = 0; i < NDIR; i++)
         run_op(dir_f3[i], dir_a[i], dir_b[i], 5'(i + 1), dir_exp[i], 0, 1'b0);

      // Stalled writeback with a pending request, and rd = x0.
      run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd0, 32'hFFFFFFEB, 5, 1'b1);
      run_op(3'd4, 32'd5, 32'd0, 5'd0, 32'hFFFFFFFF, 5, 1'b1);

      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom);
         a  = pick_operand();
         b  = pick_operand();
         run_op(f3, a, b, 5'($urandom), ref_mdu(f3, a, b), $urandom_range(0, 2), 1'($urandom));
      end

      // Flush at iteration 10.
      start_valid = 1'b1; funct3 = 3'd3; rs1_data = 32'hDEADBEEF; rs2_data = 32'h12345678;
      rd_addr_in = 5'd9;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_valid", 64'(wb_valid), 64'(0));
      check("flush_busy", 64'(busy), 64'(0));
      check("flush_ready", 64'(start_ready), 64'(1));
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (wb_valid) seen++;
      end
      check("flush_no_wb", 64'(seen), 64'(0));
      // Flush wins over a simultaneous request.
      start_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      start_valid = 1'b0; flush = 1'b0;
      check("flush_blocks_accept", 64'(busy), 64'(0));
      run_op(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 0, 1'b0);

      // Reset at iteration 20.
      start_valid = 1'b1; funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3;
      rd_addr_in = 5'd7;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ready", 64'(start_ready), 64'(0));
      check("midrst_valid", 64'(wb_valid), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_data", 64'(wb_data), 64'(0));
      check("midrst_rd", 64'(wb_rd_addr), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_release_ready", 64'(start_ready), 64'(1));
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (wb_valid) seen++;
      end
      check("rst_no_wb", 64'(seen), 64'(0));
      run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd31, 32'hFFFFFFFF, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
